// File: rtl/vec_decode_issue.sv
// Vector pipeline decode/issue stage: field split, scalar+vector reg files, RAW/WAW scoreboard, flush, writeback.
// Optional macro VEC_DECODE_WB_BYPASS_EN: same-cycle writeback clears the hazard and forwards data into the bundle.
module vec_decode_issue #(
  parameter int INSTR_W  = 20,
  parameter int SCALAR_W = 21,
  parameter int LANES    = 8,
  parameter int LANE_W   = 24,
  parameter int NREG     = 8,
  parameter int IMM_W    = 8,
  parameter int RIDX_W   = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        instr,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                out_opcode,
  output logic [SCALAR_W-1:0]       out_imm,
  output logic [RIDX_W-1:0]         out_rd,
  output logic                      out_rd_vec,
  output logic                      out_wr_en,
  output logic                      out_illegal,
  output logic [SCALAR_W-1:0]       out_rs1_s,
  output logic [SCALAR_W-1:0]       out_rs2_s,
  output logic [LANES*LANE_W-1:0]   out_rs1_v,
  output logic [LANES*LANE_W-1:0]   out_rs2_v,
  input  logic                      wb_en,
  input  logic                      wb_vec,
  input  logic [RIDX_W-1:0]         wb_addr,
  input  logic [SCALAR_W-1:0]       wb_sdata,
  input  logic [LANES*LANE_W-1:0]   wb_vdata
);

  localparam int VEC_W   = LANES * LANE_W;
  localparam int OP_LSB  = INSTR_W - 4;
  localparam int RD_LSB  = OP_LSB - RIDX_W;
  localparam int RS1_LSB = RD_LSB - RIDX_W;
  localparam int RS2_LSB = RS1_LSB - RIDX_W;
  localparam int TD_BIT  = RS2_LSB - 1;
  localparam int T1_BIT  = RS2_LSB - 2;
  localparam int T2_BIT  = RS2_LSB - 3;

  logic [3:0]        dec_op;
  logic [RIDX_W-1:0] dec_rd, dec_rs1, dec_rs2;
  logic              dec_td, dec_t1, dec_t2;
  logic              use_rs1, use_rs2, dec_wr, dec_ill;
  logic              hazard, accept;

  logic [SCALAR_W-1:0] sreg_q [NREG];
  logic [SCALAR_W-1:0] sreg_d [NREG];
  logic [VEC_W-1:0]    vreg_q [NREG];
  logic [VEC_W-1:0]    vreg_d [NREG];
  logic [NREG-1:0]     pend_s_q, pend_s_d, pend_v_q, pend_v_d;
  logic [NREG-1:0]     wb_clr_s, wb_clr_v, eff_s, eff_v;

  logic [SCALAR_W-1:0] rs1_s, rs2_s;
  logic [VEC_W-1:0]    rs1_v, rs2_v;

  logic                out_valid_q, out_valid_d;
  logic [3:0]          op_q, op_d;
  logic [SCALAR_W-1:0] imm_q, imm_d;
  logic [RIDX_W-1:0]   rd_q, rd_d;
  logic                rd_vec_q, rd_vec_d, wr_q, wr_d, ill_q, ill_d;
  logic [SCALAR_W-1:0] rs1_s_q, rs1_s_d, rs2_s_q, rs2_s_d;
  logic [VEC_W-1:0]    rs1_v_q, rs1_v_d, rs2_v_q, rs2_v_d;

  assign dec_op  = instr[OP_LSB +: 4];
  assign dec_rd  = instr[RD_LSB +: RIDX_W];
  assign dec_rs1 = instr[RS1_LSB +: RIDX_W];
  assign dec_rs2 = instr[RS2_LSB +: RIDX_W];
  assign dec_td  = instr[TD_BIT];
  assign dec_t1  = instr[T1_BIT];
  assign dec_t2  = instr[T2_BIT];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec_wr  = 1'b0;
    dec_ill = 1'b0;
    if (dec_op >= 4'h1 && dec_op <= 4'h7) begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
      dec_wr  = 1'b1;
    end else if (dec_op >= 4'h8 && dec_op <= 4'hC) begin
      use_rs1 = 1'b1;
      dec_wr  = 1'b1;
    end else if (dec_op == 4'hD) begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
    end else if (dec_op >= 4'hE) begin
      dec_ill = 1'b1;
    end
  end

  always_comb begin
    wb_clr_s = '0;
    wb_clr_v = '0;
    if (wb_en) begin
      if (wb_vec) wb_clr_v[wb_addr] = 1'b1;
      else        wb_clr_s[wb_addr] = 1'b1;
    end
  end

`ifdef VEC_DECODE_WB_BYPASS_EN
  assign eff_s = pend_s_q & ~wb_clr_s;
  assign eff_v = pend_v_q & ~wb_clr_v;
`else
  assign eff_s = pend_s_q;
  assign eff_v = pend_v_q;
`endif

  assign hazard = (use_rs1 & (dec_t1 ? eff_v[dec_rs1] : eff_s[dec_rs1]))
                | (use_rs2 & (dec_t2 ? eff_v[dec_rs2] : eff_s[dec_rs2]))
                | (dec_wr  & (dec_td ? eff_v[dec_rd]  : eff_s[dec_rd]));

  assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    rs1_s = sreg_q[dec_rs1];
    rs2_s = sreg_q[dec_rs2];
    rs1_v = vreg_q[dec_rs1];
    rs2_v = vreg_q[dec_rs2];
`ifdef VEC_DECODE_WB_BYPASS_EN
    if (wb_en && !wb_vec) begin
      if (wb_addr == dec_rs1) rs1_s = wb_sdata;
      if (wb_addr == dec_rs2) rs2_s = wb_sdata;
    end
    if (wb_en && wb_vec) begin
      if (wb_addr == dec_rs1) rs1_v = wb_vdata;
      if (wb_addr == dec_rs2) rs2_v = wb_vdata;
    end
`endif
  end

  always_comb begin
    sreg_d = sreg_q;
    vreg_d = vreg_q;
    if (wb_en) begin
      if (wb_vec) vreg_d[wb_addr] = wb_vdata;
      else        sreg_d[wb_addr] = wb_sdata;
    end

    pend_s_d = pend_s_q & ~wb_clr_s;
    pend_v_d = pend_v_q & ~wb_clr_v;
    // a bundle consumed this cycle has left the stage, so flush leaves its pending bit alone
    if (flush && out_valid_q && !out_ready && wr_q) begin
      if (rd_vec_q) pend_v_d[rd_q] = 1'b0;
      else          pend_s_d[rd_q] = 1'b0;
    end
    if (accept && dec_wr) begin
      if (dec_td) pend_v_d[dec_rd] = 1'b1;
      else        pend_s_d[dec_rd] = 1'b1;
    end

    out_valid_d = out_valid_q;
    if (accept)                 out_valid_d = 1'b1;
    else if (flush | out_ready) out_valid_d = 1'b0;

    op_d     = op_q;
    imm_d    = imm_q;
    rd_d     = rd_q;
    rd_vec_d = rd_vec_q;
    wr_d     = wr_q;
    ill_d    = ill_q;
    rs1_s_d  = rs1_s_q;
    rs2_s_d  = rs2_s_q;
    rs1_v_d  = rs1_v_q;
    rs2_v_d  = rs2_v_q;
    if (accept) begin
      op_d     = dec_op;
      imm_d    = {{(SCALAR_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
      rd_d     = dec_rd;
      rd_vec_d = dec_td;
      wr_d     = dec_wr;
      ill_d    = dec_ill;
      rs1_s_d  = rs1_s;
      rs2_s_d  = rs2_s;
      rs1_v_d  = rs1_v;
      rs2_v_d  = rs2_v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q      <= '{default: '0};
      vreg_q      <= '{default: '0};
      pend_s_q    <= '0;
      pend_v_q    <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      rd_vec_q    <= 1'b0;
      wr_q        <= 1'b0;
      ill_q       <= 1'b0;
      rs1_s_q     <= '0;
      rs2_s_q     <= '0;
      rs1_v_q     <= '0;
      rs2_v_q     <= '0;
    end else begin
      sreg_q      <= sreg_d;
      vreg_q      <= vreg_d;
      pend_s_q    <= pend_s_d;
      pend_v_q    <= pend_v_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      rd_vec_q    <= rd_vec_d;
      wr_q        <= wr_d;
      ill_q       <= ill_d;
      rs1_s_q     <= rs1_s_d;
      rs2_s_q     <= rs2_s_d;
      rs1_v_q     <= rs1_v_d;
      rs2_v_q     <= rs2_v_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = op_q;
  assign out_imm     = imm_q;
  assign out_rd      = rd_q;
  assign out_rd_vec  = rd_vec_q;
  assign out_wr_en   = wr_q;
  assign out_illegal = ill_q;
  assign out_rs1_s   = rs1_s_q;
  assign out_rs2_s   = rs2_s_q;
  assign out_rs1_v   = rs1_v_q;
  assign out_rs2_v   = rs2_v_q;

endmodule

// File: tb/tb_vec_decode_issue.sv
// Bench for vec_decode_issue: cycle model of reg files/scoreboard, expected bundles queued on accept.
module tb_vec_decode_issue;
  localparam int INSTR_W = 20, SCALAR_W = 21, LANES = 8, LANE_W = 24, NREG = 8, IMM_W = 8, RIDX_W = 3;
  localparam int VW = LANES * LANE_W;
`ifdef VEC_DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [INSTR_W-1:0] instr;
  logic [3:0] out_opcode;
  logic [SCALAR_W-1:0] out_imm, out_rs1_s, out_rs2_s, wb_sdata;
  logic [RIDX_W-1:0] out_rd, wb_addr;
  logic out_rd_vec, out_wr_en, out_illegal, wb_en, wb_vec;
  logic [VW-1:0] out_rs1_v, out_rs2_v, wb_vdata;

  always #5 clk = ~clk;

  vec_decode_issue #(.INSTR_W(INSTR_W), .SCALAR_W(SCALAR_W), .LANES(LANES), .LANE_W(LANE_W),
                     .NREG(NREG), .IMM_W(IMM_W), .RIDX_W(RIDX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_vec(out_rd_vec), .out_wr_en(out_wr_en), .out_illegal(out_illegal),
    .out_rs1_s(out_rs1_s), .out_rs2_s(out_rs2_s), .out_rs1_v(out_rs1_v), .out_rs2_v(out_rs2_v),
    .wb_en(wb_en), .wb_vec(wb_vec), .wb_addr(wb_addr), .wb_sdata(wb_sdata), .wb_vdata(wb_vdata));

  typedef struct {
    logic [3:0] op; logic [SCALAR_W-1:0] imm; logic [RIDX_W-1:0] rd;
    logic rdv, wr, ill; logic [SCALAR_W-1:0] s1, s2; logic [VW-1:0] v1, v2;
  } bund_t;
  typedef struct { logic [INSTR_W-1:0] ins; logic wr, ill; logic [7:0] imm; } vec_t;

  int errs = 0, checks = 0;
  bund_t q[$];
  logic [SCALAR_W-1:0] m_s [NREG];
  logic [VW-1:0] m_v [NREG];
  logic [NREG-1:0] m_ps, m_pv;
  logic m_ov, d_wr, d_ill, last_acc, last_dacc;
  logic [SCALAR_W-1:0] d_imm;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] r1,
                                            input logic [2:0] r2, input logic td, input logic t1, input logic t2);
    return {op, rd, r1, r2, td, t1, t2, 4'b0000};
  endfunction

  function automatic logic [VW-1:0] rv();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void classes(input logic [3:0] op, output logic u1, output logic u2, output logic w);
    u1 = (op != 4'h0) && (op <= 4'hD);
    u2 = ((op != 4'h0) && (op <= 4'h7)) || (op == 4'hD);
    w  = (op != 4'h0) && (op <= 4'hC);
  endfunction

  function automatic logic pend(input logic vec, input logic [2:0] idx);
    logic p;
    p = vec ? m_pv[idx] : m_ps[idx];
    if (BYP && wb_en && (wb_vec == vec) && (wb_addr == idx)) p = 1'b0;
    return p;
  endfunction

  function automatic logic [SCALAR_W-1:0] rds(input logic [2:0] idx);
    if (BYP && wb_en && !wb_vec && wb_addr == idx) return wb_sdata;
    return m_s[idx];
  endfunction

  function automatic logic [VW-1:0] rdvv(input logic [2:0] idx);
    if (BYP && wb_en && wb_vec && wb_addr == idx) return wb_vdata;
    return m_v[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin m_s[i] = '0; m_v[i] = '0; end
    m_ps = '0; m_pv = '0; m_ov = 1'b0; q.delete();
  endtask

  // one clock: check at negedge against the model, then advance the model at the posedge
  task automatic cycle();
    logic [3:0] op; logic [2:0] rd, r1, r2; logic td, t1, t2, u1, u2, w, haz, rdy, acc; bund_t b;
    @(negedge clk);
    op = instr[19:16]; rd = instr[15:13]; r1 = instr[12:10]; r2 = instr[9:7];
    td = instr[6]; t1 = instr[5]; t2 = instr[4];
    classes(op, u1, u2, w);
    haz = (u1 && pend(t1, r1)) || (u2 && pend(t2, r2)) || (w && pend(td, rd));
    rdy = (!m_ov || out_ready) && !haz && !flush;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      if (q.size() == 0) begin
        checks++; errs++;
        $display("FAIL scoreboard_empty: got out_valid=1 expected a queued bundle");
      end else begin
        chk("out_opcode", out_opcode, q[0].op);
        chk("out_imm", out_imm, q[0].imm);
        chk("out_rd", out_rd, q[0].rd);
        chk("out_rd_vec", out_rd_vec, q[0].rdv);
        chk("out_wr_en", out_wr_en, q[0].wr);
        chk("out_illegal", out_illegal, q[0].ill);
        chk("out_rs1_s", out_rs1_s, q[0].s1);
        chk("out_rs2_s", out_rs2_s, q[0].s2);
        chk("out_rs1_v", out_rs1_v, q[0].v1);
        chk("out_rs2_v", out_rs2_v, q[0].v2);
      end
    end
    acc = in_valid && rdy;
    last_dacc = in_valid && in_ready;
    b.op = op; b.imm = d_imm; b.rd = rd; b.rdv = td; b.wr = d_wr; b.ill = d_ill;
    b.s1 = rds(r1); b.s2 = rds(r2); b.v1 = rdvv(r1); b.v2 = rdvv(r2);
    @(posedge clk);
    if (wb_en) begin
      if (wb_vec) begin m_v[wb_addr] = wb_vdata; m_pv[wb_addr] = 1'b0; end
      else begin m_s[wb_addr] = wb_sdata; m_ps[wb_addr] = 1'b0; end
    end
    if (m_ov && out_ready && q.size() > 0) void'(q.pop_front());
    else if (m_ov && flush && q.size() > 0) begin
      if (q[0].wr) begin
        if (q[0].rdv) m_pv[q[0].rd] = 1'b0; else m_ps[q[0].rd] = 1'b0;
      end
      void'(q.pop_front());
    end
    if (acc && w) begin
      if (td) m_pv[rd] = 1'b1; else m_ps[rd] = 1'b1;
    end
    if (acc) m_ov = 1'b1;
    else if (flush || out_ready) m_ov = 1'b0;
    if (acc) q.push_back(b);
    last_acc = acc;
    #1;
  endtask

  task automatic issue(input logic [INSTR_W-1:0] ins, input logic wr, input logic ill, input logic [7:0] imm,
                       output int dn);
    instr = ins; d_wr = wr; d_ill = ill; d_imm = {{(SCALAR_W-IMM_W){1'b0}}, imm}; in_valid = 1'b1; dn = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_dacc && dn == 0) dn = i + 1;
      if (last_acc) break;
    end
    if (!last_acc) begin
      checks++; errs++;
      $display("FAIL issue_timeout: instr %0h got no accept, expected accept within 20 cycles", ins);
    end
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic vec, input logic [2:0] addr, input logic [SCALAR_W-1:0] sd, input logic [VW-1:0] vd);
    wb_en = 1'b1; wb_vec = vec; wb_addr = addr; wb_sdata = sd; wb_vdata = vd;
    cycle();
    wb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end within 200000 time units");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int n;
    tbl[0] = '{20'h00000, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{20'h32D85, 1'b1, 1'b0, 8'h85};
    tbl[2] = '{20'h94C3C, 1'b1, 1'b0, 8'h3C};
    tbl[3] = '{20'hCA440, 1'b1, 1'b0, 8'h40};
    tbl[4] = '{20'hD0D07, 1'b0, 1'b0, 8'h07};
    tbl[5] = '{20'hE1234, 1'b0, 1'b1, 8'h34};
    tbl[6] = '{20'hBE4FF, 1'b1, 1'b0, 8'hFF};
    tbl[7] = '{20'h71F3A, 1'b1, 1'b0, 8'h3A};

    rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_vec = 1'b0; wb_addr = '0; wb_sdata = '0; wb_vdata = '0;
    d_wr = 1'b0; d_ill = 1'b0; d_imm = '0; last_acc = 1'b0; last_dacc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycle();

    // reset mid-stream with a held bundle, then reads must see cleared files
    wb(1'b0, 3'd3, 21'h1F0F0, '0);
    wb(1'b1, 3'd3, '0, rv());
    out_ready = 1'b0;
    issue(mk(4'h1, 3'd1, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 8'h80, n);
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", out_valid, 1'b0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    instr = '0; d_wr = 1'b0;
    cycle();
    issue(mk(4'h1, 3'd6, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 8'h80, n);
    issue(mk(4'h1, 3'd6, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1), 1'b1, 1'b0, 8'hF0, n);
    wb(1'b0, 3'd6, 21'h00011, '0);
    wb(1'b1, 3'd6, '0, rv());

    // scalar write then ADD reading it on both sources
    wb(1'b0, 3'd3, 21'h1ABCD, '0);
    issue(mk(4'h1, 3'd1, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 8'h80, n);
    wb(1'b0, 3'd1, 21'h0BEEF, '0);

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].ins, tbl[i].wr, tbl[i].ill, tbl[i].imm, n);
      if (tbl[i].wr) wb(tbl[i].ins[6], tbl[i].ins[15:13], 21'($urandom), rv());
      else cycle();
    end

    // RAW on vector r2: stall until writeback, accept point depends on bypass build
    issue(mk(4'h1, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 8'h40, n);
    instr = mk(4'h1, 3'd4, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0); d_wr = 1'b1; d_ill = 1'b0; d_imm = 21'h60;
    in_valid = 1'b1;
    repeat (3) cycle();
    wb(1'b1, 3'd2, '0, rv());
    n = last_dacc ? 0 : 99;
    for (int i = 1; i <= 5 && n == 99; i++) begin
      cycle();
      if (last_dacc) n = i;
    end
    chk("raw_extra_stall_cycles", n, BYP ? 0 : 1);
    in_valid = 1'b0;
    wb(1'b1, 3'd4, '0, rv());

    // backpressure: held bundle stable for 5 cycles, then next instr accepted in the release cycle
    out_ready = 1'b0;
    issue(mk(4'h8, 3'd6, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 8'h00, n);
    instr = mk(4'h2, 3'd7, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0); d_wr = 1'b1; d_ill = 1'b0; d_imm = 21'h80;
    in_valid = 1'b1;
    repeat (5) cycle();
    out_ready = 1'b1;
    issue(mk(4'h2, 3'd7, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 8'h80, n);
    chk("bp_accept_on_release", n, 1);
    cycle();

    // flush a held reg-imm to scalar r5, then a reader of r5 issues at once
    out_ready = 1'b0;
    issue(mk(4'h8, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 8'h00, n);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    out_ready = 1'b1;
    issue(mk(4'hC, 3'd0, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 8'h00, n);
    chk("flush_reader_no_stall", n, 1);
    cycle();

    // illegal opcode sets no pending bit: WAW on its rd field issues immediately
    issue(20'hF00FF, 1'b0, 1'b1, 8'hFF, n);
    issue(mk(4'h1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1), 1'b1, 1'b0, 8'h70, n);
    chk("illegal_no_pending", n, 1);
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
